// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one two-cycle ALU; responses are held per port until consumed.
// Define ALU_ARB_RR_EN for a round-robin tie-break; otherwise port 0 wins every tie.
module alu_arbiter #(
    parameter int NUM_PORTS = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_ready,
    input  logic [NUM_PORTS-1:0][31:0]  req_a,
    input  logic [NUM_PORTS-1:0][31:0]  req_b,
    input  logic [NUM_PORTS-1:0][2:0]   req_fn,
    input  logic [NUM_PORTS-1:0]        req_mod,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    input  logic [NUM_PORTS-1:0]        rsp_ready,
    output logic [NUM_PORTS-1:0][31:0]  rsp_data,
    output logic [31:0]                 alu_a,
    output logic [31:0]                 alu_b,
    output logic [2:0]                  alu_fn,
    output logic                        alu_mod,
    input  logic [31:0]                 alu_result
);

    logic [1:0]        inflight_r;
    logic [1:0]        rsp_valid_r;
    logic [1:0][31:0]  rsp_data_r;
    logic              issue_valid_r;
    logic              issue_port_r;
    logic [1:0]        eligible_s;
    logic [1:0]        grant_s;
    logic [1:0]        capture_s;

`ifdef ALU_ARB_RR_EN
    logic              last_grant_r;
`endif

    // Eligibility: a port needs a request, nothing in flight, and room for its result.
    always_comb begin
        eligible_s = req_valid & ~inflight_r & (~rsp_valid_r | rsp_ready);
    end

    // Arbitration; no grants while reset is asserted.
    always_comb begin
        grant_s = 2'b00;
        if (!rst_n) begin
            grant_s = 2'b00;
        end else if (eligible_s == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            grant_s = last_grant_r ? 2'b01 : 2'b10;
`else
            grant_s = 2'b01;
`endif
        end else begin
            grant_s = eligible_s;
        end
    end

    // ALU operand mux; idle cycles issue a harmless all-zero add.
    always_comb begin
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_fn  = 3'd0;
        alu_mod = 1'b0;
        if (grant_s[1]) begin
            alu_a   = req_a[1];
            alu_b   = req_b[1];
            alu_fn  = req_fn[1];
            alu_mod = req_mod[1];
        end else if (grant_s[0]) begin
            alu_a   = req_a[0];
            alu_b   = req_b[0];
            alu_fn  = req_fn[0];
            alu_mod = req_mod[0];
        end else begin
            alu_a   = 32'd0;
            alu_b   = 32'd0;
            alu_fn  = 3'd0;
            alu_mod = 1'b0;
        end
    end

    // The ALU result present this cycle belongs to whichever port issued last cycle.
    always_comb begin
        capture_s[0] = issue_valid_r & ~issue_port_r;
        capture_s[1] = issue_valid_r &  issue_port_r;
    end

    // Issue tracking: remembers which port owns the operation now inside the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_r <= 1'b0;
            issue_port_r  <= 1'b0;
        end else begin
            issue_valid_r <= |grant_s;
            if (|grant_s) begin
                issue_port_r <= grant_s[1];
            end else begin
                issue_port_r <= issue_port_r;
            end
        end
    end

    // Per-port in-flight flag and response holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r  <= 2'b00;
            rsp_valid_r <= 2'b00;
            rsp_data_r  <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (grant_s[k]) begin
                    inflight_r[k] <= 1'b1;
                end else if (capture_s[k]) begin
                    inflight_r[k] <= 1'b0;
                end else begin
                    inflight_r[k] <= inflight_r[k];
                end
                // A capture wins over a same-edge pop so the new result is not lost.
                if (capture_s[k]) begin
                    rsp_valid_r[k] <= 1'b1;
                    rsp_data_r[k]  <= alu_result;
                end else if (rsp_valid_r[k] && rsp_ready[k]) begin
                    rsp_valid_r[k] <= 1'b0;
                end else begin
                    rsp_valid_r[k] <= rsp_valid_r[k];
                end
            end
        end
    end

`ifdef ALU_ARB_RR_EN
    // Round-robin pointer: reset value 1 lets port 0 take the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b1;
        end else if (|grant_s) begin
            last_grant_r <= grant_s[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`endif

    assign req_ready = grant_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter with a behavioural two-cycle ALU.
module tb_alu_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_a;
    logic [1:0][31:0]  req_b;
    logic [1:0][2:0]   req_fn;
    logic [1:0]        req_mod;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_data;
    logic [31:0]       alu_a;
    logic [31:0]       alu_b;
    logic [2:0]        alu_fn;
    logic              alu_mod;
    logic [31:0]       alu_result;

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.NUM_PORTS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_fn(req_fn), .req_mod(req_mod),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_mod(alu_mod),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] fn, input logic md);
        case (fn)
            3'd0:    alu_f = md ? a - b : a + b;
            3'd1:    alu_f = a << b[4:0];
            3'd2:    alu_f = {31'd0, $signed(a) < $signed(b)};
            3'd3:    alu_f = {31'd0, a < b};
            3'd4:    alu_f = a ^ b;
            3'd5:    alu_f = md ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    alu_f = a | b;
            default: alu_f = md ? a & ~b : a & b;
        endcase
    endfunction

    // Behavioural ALU: operands sampled on the edge, result valid the next cycle.
    always_ff @(posedge clk) begin
        alu_result <= alu_f(alu_a, alu_b, alu_fn, alu_mod);
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] fn, input logic md);
        req_a[k]   = a;
        req_b[k]   = b;
        req_fn[k]  = fn;
        req_mod[k] = md;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        logic [1:0] tie_exp;
        rst_n     = 1'b0;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        set_req(0, 32'd1, 32'd2, 3'd0, 1'b0);
        set_req(1, 32'd3, 32'd4, 3'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_vec("reset_req_ready", {30'd0, req_ready}, 32'd0);
        check_vec("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check_vec("reset_rsp_data0", rsp_data[0], 32'd0);
        check_vec("reset_alu_a", alu_a, 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        cyc();

        // Single add on port 0
        set_req(0, 32'd5, 32'd7, 3'd0, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        check_vec("single_ready", {30'd0, req_ready}, 32'd1);
        check_vec("single_alu_a", alu_a, 32'd5);
        check_vec("single_alu_b", alu_b, 32'd7);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        check_vec("single_n1_valid", {30'd0, rsp_valid}, 32'd0);
        cyc();
        @(negedge clk);
        check_vec("single_n2_valid", {30'd0, rsp_valid}, 32'd1);
        check_vec("single_n2_data", rsp_data[0], 32'd12);
        cyc();
        @(negedge clk);
        check_vec("single_n3_valid", {30'd0, rsp_valid}, 32'd0);

        // Tie after a port-0 grant separates round-robin from fixed priority
        cyc();
        set_req(0, 32'd1, 32'd1, 3'd0, 1'b0);
        set_req(1, 32'd2, 32'd2, 3'd0, 1'b0);
        req_valid = 2'b11;
`ifdef ALU_ARB_RR_EN
        tie_exp = 2'b10;
`else
        tie_exp = 2'b01;
`endif
        @(negedge clk);
        check_vec("tie_after_p0", {30'd0, req_ready}, {30'd0, tie_exp});
        do_reset();

        // Continuous contention: p0 sub 10-3, p1 xor F0^0F
        set_req(0, 32'd10, 32'd3, 3'd0, 1'b1);
        set_req(1, 32'hF0, 32'h0F, 3'd4, 1'b0);
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_vec($sformatf("cont_ready_%0d", i), {30'd0, req_ready},
                      (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i >= 2) begin
                check_vec($sformatf("cont_valid_%0d", i), {30'd0, rsp_valid},
                          (i % 2 == 0) ? 32'd1 : 32'd2);
                if (i % 2 == 0) check_vec($sformatf("cont_data0_%0d", i), rsp_data[0], 32'd7);
                else            check_vec($sformatf("cont_data1_%0d", i), rsp_data[1], 32'hFF);
            end
            cyc();
        end
        do_reset();

        // Backpressure on port 1: sltu 1<2 held while rsp_ready[1] low
        set_req(1, 32'd1, 32'd2, 3'd3, 1'b0);
        req_valid = 2'b10;
        rsp_ready = 2'b01;
        @(negedge clk);
        check_vec("bp_accept", {30'd0, req_ready}, 32'd2);
        cyc();
        set_req(1, 32'd3, 32'd4, 3'd0, 1'b0);
        @(negedge clk);
        check_vec("bp_inflight_ready", {30'd0, req_ready}, 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_vec($sformatf("bp_hold_valid_%0d", i), {30'd0, rsp_valid}, 32'd2);
            check_vec($sformatf("bp_hold_data_%0d", i), rsp_data[1], 32'd1);
            check_vec($sformatf("bp_hold_ready_%0d", i), {30'd0, req_ready}, 32'd0);
            cyc();
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check_vec("bp_pop_accept", {30'd0, req_ready}, 32'd2);
        cyc();
        req_valid = 2'b00;
        @(negedge clk);
        check_vec("bp_after_pop", {30'd0, rsp_valid}, 32'd0);
        cyc();
        @(negedge clk);
        check_vec("bp_next_valid", {30'd0, rsp_valid}, 32'd2);
        check_vec("bp_next_data", rsp_data[1], 32'd7);
        cyc();

        // Arithmetic and logical right shift on port 0
        set_req(0, 32'h8000_0000, 32'd4, 3'd5, 1'b1);
        req_valid = 2'b01;
        @(negedge clk);
        check_vec("sra_accept", {30'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 2'b00;
        cyc();
        @(negedge clk);
        check_vec("sra_data", rsp_data[0], 32'hF800_0000);
        cyc();
        set_req(0, 32'h8000_0000, 32'd4, 3'd5, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        check_vec("srl_accept", {30'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 2'b00;
        cyc();
        @(negedge clk);
        check_vec("srl_data", rsp_data[0], 32'h0800_0000);
        cyc();

        // Reset in the cycle after an accept discards the operation
        set_req(0, 32'd9, 32'd9, 3'd0, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        check_vec("rst_flight_accept", {30'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 2'b00;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_vec("rst_flight_in_reset", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            check_vec($sformatf("rst_flight_quiet_%0d", i), {30'd0, rsp_valid}, 32'd0);
        end
        check_vec("rst_flight_data0", rsp_data[0], 32'd0);
        cyc();
        set_req(0, 32'd1, 32'd1, 3'd0, 1'b0);
        set_req(1, 32'd2, 32'd2, 3'd0, 1'b0);
        req_valid = 2'b11;
        @(negedge clk);
        check_vec("rst_first_tie", {30'd0, req_ready}, 32'd1);
        cyc();
        req_valid = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
